// File: rtl/mem_pkg.sv
// Shared definitions for the memory-access stage.
// Contents: bus widths, load/store aluop codes, byte-lane select width,
// zero constants for reset/bubble outputs and the stage FSM encoding.
package mem_pkg;

  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 5;
  localparam int ALU_OP_W   = 8;
  localparam int SEL_W      = 4;

  // Load/store operation codes carried on ex_aluop.
  localparam logic [ALU_OP_W-1:0] EXE_LB_OP  = 8'b1110_0000;
  localparam logic [ALU_OP_W-1:0] EXE_LBU_OP = 8'b1110_0100;
  localparam logic [ALU_OP_W-1:0] EXE_LH_OP  = 8'b1110_0001;
  localparam logic [ALU_OP_W-1:0] EXE_LHU_OP = 8'b1110_0101;
  localparam logic [ALU_OP_W-1:0] EXE_LW_OP  = 8'b1110_0011;
  localparam logic [ALU_OP_W-1:0] EXE_SB_OP  = 8'b1110_1000;
  localparam logic [ALU_OP_W-1:0] EXE_SH_OP  = 8'b1110_1001;
  localparam logic [ALU_OP_W-1:0] EXE_SW_OP  = 8'b1110_1011;

  localparam logic [DATA_W-1:0]     ZERO_DATA      = '0;
  localparam logic [REG_ADDR_W-1:0] ZERO_DATA_ADDR = '0;
  localparam logic [SEL_W-1:0]      ZERO_SEL       = '0;
  localparam logic                  WRITE_DISABLE  = 1'b0;

  typedef enum logic {
    MEM_IDLE = 1'b0,
    MEM_WAIT = 1'b1
  } mem_state_t;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } mem_size_t;

endpackage

// File: rtl/mem_lane.sv
// Combinational byte-lane logic for the memory stage.
// Inputs : aluop, offset (addr[1:0]), reg2 (store data), rdata (bus read data)
// Outputs: is_mem / is_load decode, misalign flag, big-endian byte-lane
//          select, lane-replicated store data, extracted/extended load data.
module mem_lane
  import mem_pkg::*;
(
  input  logic [ALU_OP_W-1:0] aluop,
  input  logic [1:0]          offset,
  input  logic [DATA_W-1:0]   reg2,
  input  logic [DATA_W-1:0]   rdata,
  output logic                is_mem,
  output logic                is_load,
  output logic                misalign,
  output logic [SEL_W-1:0]    sel,
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W-1:0]   rdata_ext
);

  mem_size_t   size;
  logic        sign_ext;
  logic [7:0]  byte_val;
  logic [15:0] half_val;

  always_comb begin
    is_mem   = 1'b1;
    is_load  = 1'b1;
    sign_ext = 1'b0;
    size     = SZ_WORD;
    case (aluop)
      EXE_LB_OP:  begin size = SZ_BYTE; sign_ext = 1'b1; end
      EXE_LBU_OP: size = SZ_BYTE;
      EXE_LH_OP:  begin size = SZ_HALF; sign_ext = 1'b1; end
      EXE_LHU_OP: size = SZ_HALF;
      EXE_LW_OP:  size = SZ_WORD;
      EXE_SB_OP:  begin size = SZ_BYTE; is_load = 1'b0; end
      EXE_SH_OP:  begin size = SZ_HALF; is_load = 1'b0; end
      EXE_SW_OP:  begin size = SZ_WORD; is_load = 1'b0; end
      default:    begin is_mem = 1'b0; is_load = 1'b0; end
    endcase
  end

  always_comb begin
    misalign = 1'b0;
    if (is_mem) begin
      if (size == SZ_HALF) misalign = offset[0];
      if (size == SZ_WORD) misalign = (offset != 2'b00);
    end
  end

  // Lane 3 (bits 31:24) holds address offset 0: big-endian ordering.
  always_comb begin
    sel = ZERO_SEL;
    if (is_mem) begin
      case (size)
        SZ_BYTE: sel = 4'b1000 >> offset;
        SZ_HALF: sel = offset[1] ? 4'b0011 : 4'b1100;
        default: sel = 4'b1111;
      endcase
    end
  end

  // Store data is replicated so the addressed lanes see it wherever they are.
  for (genvar gi = 0; gi < SEL_W; gi++) begin : g_wlane
    assign wdata[8*gi +: 8] = (size == SZ_BYTE) ? reg2[7:0] :
                              (size == SZ_HALF) ? reg2[8*(gi%2) +: 8] :
                                                  reg2[8*gi +: 8];
  end

  always_comb begin
    case (offset)
      2'd0:    byte_val = rdata[31:24];
      2'd1:    byte_val = rdata[23:16];
      2'd2:    byte_val = rdata[15:8];
      default: byte_val = rdata[7:0];
    endcase
    half_val = offset[1] ? rdata[15:0] : rdata[31:16];
  end

  always_comb begin
    case (size)
      SZ_BYTE: rdata_ext = {{24{sign_ext & byte_val[7]}}, byte_val};
      SZ_HALF: rdata_ext = {{16{sign_ext & half_val[15]}}, half_val};
      default: rdata_ext = rdata;
    endcase
  end

endmodule

// File: rtl/mem.sv
// Memory-access pipeline stage.
// Passes ALU results straight through to mem_wb, and runs loads/stores on the
// data-memory bus with a req/ack handshake, stalling upstream while a transfer
// is pending. A transfer that sees no ack within TIMEOUT cycles is abandoned
// with a one-cycle bus_err; misaligned accesses raise a one-cycle excp_align.
// Ports: clk/rst; ex_* from ex_mem; dmem_* data bus; mem_* write-back triple
//        to mem_wb; stall_req to ctrl; excp_align / bus_err exception flags.
module mem
  import mem_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_W-1:0]     ex_wdata,
  input  logic [REG_ADDR_W-1:0] ex_waddr,
  input  logic                  ex_we,
  input  logic [ALU_OP_W-1:0]   ex_aluop,
  input  logic [DATA_W-1:0]     ex_mem_addr,
  input  logic [DATA_W-1:0]     ex_reg2,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [DATA_W-1:0]     dmem_addr,
  output logic [SEL_W-1:0]      dmem_sel,
  output logic [DATA_W-1:0]     dmem_wdata,
  input  logic [DATA_W-1:0]     dmem_rdata,
  input  logic                  dmem_ack,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [REG_ADDR_W-1:0] mem_waddr,
  output logic                  mem_we,
  output logic                  stall_req,
  output logic                  excp_align,
  output logic                  bus_err
);

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  mem_state_t  state_reg, state_next;
  logic [7:0]  cnt_reg, cnt_next;

  logic                is_mem, is_load, misalign;
  logic [SEL_W-1:0]    lane_sel;
  logic [DATA_W-1:0]   lane_wdata, lane_rdata;

  mem_lane u_lane (
    .aluop     (ex_aluop),
    .offset    (ex_mem_addr[1:0]),
    .reg2      (ex_reg2),
    .rdata     (dmem_rdata),
    .is_mem    (is_mem),
    .is_load   (is_load),
    .misalign  (misalign),
    .sel       (lane_sel),
    .wdata     (lane_wdata),
    .rdata_ext (lane_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= MEM_IDLE;
      cnt_reg   <= 8'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = MEM_IDLE;
    cnt_next   = 8'd0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    dmem_addr  = ZERO_DATA;
    dmem_sel   = ZERO_SEL;
    dmem_wdata = ZERO_DATA;
    mem_wdata  = ZERO_DATA;
    mem_waddr  = ZERO_DATA_ADDR;
    mem_we     = WRITE_DISABLE;
    stall_req  = 1'b0;
    excp_align = 1'b0;
    bus_err    = 1'b0;

    if (!rst) begin
      mem_wdata = ex_wdata;
      mem_waddr = ex_waddr;
      mem_we    = ex_we;

      if (is_mem && misalign) begin
        mem_we     = WRITE_DISABLE;
        excp_align = 1'b1;
      end else if (is_mem) begin
        dmem_req   = 1'b1;
        dmem_we    = !is_load;
        dmem_addr  = {ex_mem_addr[DATA_W-1:2], 2'b00};
        dmem_sel   = lane_sel;
        dmem_wdata = lane_wdata;

        if (dmem_ack) begin
          if (is_load) mem_wdata = lane_rdata;
          else         mem_we    = WRITE_DISABLE;
        end else if (state_reg == MEM_WAIT && cnt_reg >= CNT_LAST) begin
          // Give up: release the pipeline and drop the instruction.
          mem_we  = WRITE_DISABLE;
          bus_err = 1'b1;
        end else begin
          // Bubble into mem_wb while the upstream stages are held.
          mem_we     = WRITE_DISABLE;
          stall_req  = 1'b1;
          state_next = MEM_WAIT;
          cnt_next   = cnt_reg + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem.sv
module tb_mem;
  import mem_pkg::*;

  localparam logic [7:0] ALU_OR = 8'b0010_0101;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ex_wdata, ex_mem_addr, ex_reg2, dmem_rdata;
  logic [4:0]  ex_waddr;
  logic        ex_we, dmem_ack;
  logic [7:0]  ex_aluop;
  logic        dmem_req, dmem_we, mem_we, stall_req, excp_align, bus_err;
  logic [31:0] dmem_addr, dmem_wdata, mem_wdata;
  logic [3:0]  dmem_sel;
  logic [4:0]  mem_waddr;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .ex_wdata(ex_wdata), .ex_waddr(ex_waddr), .ex_we(ex_we),
    .ex_aluop(ex_aluop), .ex_mem_addr(ex_mem_addr), .ex_reg2(ex_reg2),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_sel(dmem_sel), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .mem_wdata(mem_wdata), .mem_waddr(mem_waddr), .mem_we(mem_we),
    .stall_req(stall_req), .excp_align(excp_align), .bus_err(bus_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic drive(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] reg2,
                       input logic [31:0] wd, input logic [4:0] wa, input logic we,
                       input logic [31:0] rd, input logic ack);
    ex_aluop = op; ex_mem_addr = addr; ex_reg2 = reg2;
    ex_wdata = wd; ex_waddr = wa; ex_we = we;
    dmem_rdata = rd; dmem_ack = ack;
  endtask

  task automatic check_flags(input string tag, input logic req, input logic stl,
                             input logic al, input logic be, input logic we);
    check({tag, ".req"},   32'(dmem_req),   32'(req));
    check({tag, ".stall"}, 32'(stall_req),  32'(stl));
    check({tag, ".align"}, 32'(excp_align), 32'(al));
    check({tag, ".buserr"},32'(bus_err),    32'(be));
    check({tag, ".we"},    32'(mem_we),     32'(we));
  endtask

  initial begin
    rst = 1'b1;
    drive(ALU_OR, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0, 1'b0);
    tick(); tick();

    // Reset: outputs forced to zero even with live inputs.
    drive(EXE_LW_OP, 32'h200, 32'h55, 32'hCAFE0001, 5'd9, 1'b1, 32'h1, 1'b1);
    settle();
    check("rst.wdata", mem_wdata, 32'h0);
    check("rst.waddr", 32'(mem_waddr), 32'h0);
    check("rst.addr",  dmem_addr, 32'h0);
    check_flags("rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    $display("txn reset: outputs zero");
    tick();
    rst = 1'b0;

    // ALU pass-through.
    drive(ALU_OR, 32'h0, 32'h0, 32'h12345678, 5'd5, 1'b1, 32'h0, 1'b0);
    settle();
    check("alu.wdata", mem_wdata, 32'h12345678);
    check("alu.waddr", 32'(mem_waddr), 32'd5);
    check_flags("alu", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    $display("txn alu: wdata=%h waddr=%0d we=%b", mem_wdata, mem_waddr, mem_we);
    tick();

    // LB / LBU at 0x103, ack in the 4th cycle.
    for (int k = 0; k < 2; k++) begin
      drive(k == 0 ? EXE_LB_OP : EXE_LBU_OP, 32'h103, 32'h0, 32'h0, 5'd7, 1'b1, 32'h000000F0, 1'b0);
      for (int c = 0; c < 3; c++) begin
        settle();
        check_flags("lb.wait", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        check("lb.sel",  32'(dmem_sel), 32'h1);
        check("lb.addr", dmem_addr, 32'h100);
        check("lb.dwe",  32'(dmem_we), 32'h0);
        tick();
      end
      dmem_ack = 1'b1;
      settle();
      check_flags("lb.ack", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      check("lb.data", mem_wdata, k == 0 ? 32'hFFFFFFF0 : 32'h000000F0);
      check("lb.waddr", 32'(mem_waddr), 32'd7);
      $display("txn %s: mem_wdata=%h", k == 0 ? "lb" : "lbu", mem_wdata);
      tick();
    end

    // SH at 0x102, zero-wait.
    drive(EXE_SH_OP, 32'h102, 32'hAAAABEEF, 32'h0, 5'd3, 1'b0, 32'h0, 1'b1);
    settle();
    check_flags("sh", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("sh.sel",   32'(dmem_sel), 32'h3);
    check("sh.wdata", dmem_wdata, 32'hBEEFBEEF);
    check("sh.dwe",   32'(dmem_we), 32'h1);
    check("sh.addr",  dmem_addr, 32'h100);
    $display("txn sh: sel=%b wdata=%h", dmem_sel, dmem_wdata);
    tick();

    // SB at 0x101, zero-wait.
    drive(EXE_SB_OP, 32'h101, 32'h000000A5, 32'h0, 5'd3, 1'b0, 32'h0, 1'b1);
    settle();
    check("sb.sel",   32'(dmem_sel), 32'h4);
    check("sb.wdata", dmem_wdata, 32'hA5A5A5A5);
    $display("txn sb: sel=%b wdata=%h", dmem_sel, dmem_wdata);
    tick();

    // LH at 0x102 (low half, sign-extended), zero-wait.
    drive(EXE_LH_OP, 32'h102, 32'h0, 32'h0, 5'd4, 1'b1, 32'h1234ABCD, 1'b1);
    settle();
    check("lh.sel",  32'(dmem_sel), 32'h3);
    check("lh.data", mem_wdata, 32'hFFFFABCD);
    check_flags("lh", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    $display("txn lh: mem_wdata=%h", mem_wdata);
    tick();

    // LHU at 0x100 (high half, zero-extended).
    drive(EXE_LHU_OP, 32'h100, 32'h0, 32'h0, 5'd4, 1'b1, 32'h9876ABCD, 1'b1);
    settle();
    check("lhu.sel",  32'(dmem_sel), 32'hC);
    check("lhu.data", mem_wdata, 32'h00009876);
    $display("txn lhu: mem_wdata=%h", mem_wdata);
    tick();

    // LW aligned, zero-wait.
    drive(EXE_LW_OP, 32'h104, 32'h0, 32'h0, 5'd6, 1'b1, 32'hDEADBEEF, 1'b1);
    settle();
    check("lw.sel",  32'(dmem_sel), 32'hF);
    check("lw.data", mem_wdata, 32'hDEADBEEF);
    check("lw.addr", dmem_addr, 32'h104);
    $display("txn lw: mem_wdata=%h", mem_wdata);
    tick();

    // LW misaligned.
    drive(EXE_LW_OP, 32'h102, 32'h0, 32'h0, 5'd6, 1'b1, 32'h0, 1'b0);
    settle();
    check_flags("lwmis", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    $display("txn lw misaligned: excp_align=%b", excp_align);
    tick();
    drive(ALU_OR, 32'h0, 32'h0, 32'h00000011, 5'd2, 1'b1, 32'h0, 1'b0);
    settle();
    check_flags("postmis", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();

    // LW timeout (TIMEOUT=4): 3 stall cycles, bus_err in the 4th.
    drive(EXE_LW_OP, 32'h108, 32'h0, 32'h0, 5'd8, 1'b1, 32'h0, 1'b0);
    for (int c = 0; c < 3; c++) begin
      settle();
      check_flags("to.wait", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
    end
    settle();
    check_flags("to.err", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    $display("txn lw timeout: bus_err=%b", bus_err);
    tick();
    // Late ack while an ALU op is in the stage.
    drive(ALU_OR, 32'h0, 32'h0, 32'h00C0FFEE, 5'd10, 1'b1, 32'hBAD0BAD0, 1'b1);
    settle();
    check_flags("late", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("late.wdata", mem_wdata, 32'h00C0FFEE);
    $display("txn late ack: ignored, mem_wdata=%h", mem_wdata);
    tick();

    // Reset during the 2nd WAIT cycle.
    drive(EXE_LW_OP, 32'h10C, 32'h0, 32'h0, 5'd12, 1'b1, 32'h0, 1'b0);
    tick(); tick();
    rst = 1'b1;
    settle();
    check("rstw.wdata", mem_wdata, 32'h0);
    check("rstw.addr",  dmem_addr, 32'h0);
    check("rstw.sel",   32'(dmem_sel), 32'h0);
    check_flags("rstw", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    rst = 1'b0;
    // Same LW again: a cleared counter gives the full 3 stall cycles.
    for (int c = 0; c < 3; c++) begin
      settle();
      check_flags("rstw.wait", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
    end
    settle();
    check_flags("rstw.err", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    $display("txn reset mid-wait: recovered, timeout after 3 stalls");
    tick();
    drive(ALU_OR, 32'h0, 32'h0, 32'h0BADF00D, 5'd31, 1'b1, 32'h0, 1'b0);
    settle();
    check("post.wdata", mem_wdata, 32'h0BADF00D);
    check("post.waddr", 32'(mem_waddr), 32'd31);
    check_flags("post", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    $display("txn alu after reset: wdata=%h", mem_wdata);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem.md
# mem

Memory-access stage of the five-stage pipeline, between the ex_mem and mem_wb pipeline registers. It passes ALU results through unchanged and executes loads and stores against the data-memory bus with a req/ack handshake. While a transfer is outstanding it stalls the pipeline. It produces the write-back triple (data, register address, write enable) that mem_wb latches.

## Interface
- TIMEOUT, 16: cycles allowed in WAIT before a bus error; range 1..255.
- clk  in  1  pipeline clock; all state changes on the rising edge
- rst  in  1  synchronous reset, active-high (`RstEnable`)
- ex_wdata  in  `DataBus`  ALU result / link value
- ex_waddr  in  `RegAddrBus`  destination register
- ex_we  in  1  register write enable
- ex_aluop  in  `AluOpBus`  operation; load/store codes EXE_LB/LBU/LH/LHU/LW/SB/SH/SW_OP from defines.v
- ex_mem_addr  in  `DataBus`  effective address
- ex_reg2  in  `DataBus`  store data (rt)
- dmem_req  out  1  transfer request
- dmem_we  out  1  1 = store
- dmem_addr  out  `DataBus`  word address; bits [1:0] forced to 0
- dmem_sel  out  4  byte-lane enables; bit 3 = addr offset 0 (big-endian)
- dmem_wdata  out  `DataBus`  store data replicated into the lanes
- dmem_rdata  in  `DataBus`  read data, valid when dmem_ack=1
- dmem_ack  in  1  transfer complete; may arrive in the same cycle as req
- mem_wdata  out  `DataBus`  to mem_wb
- mem_waddr  out  `RegAddrBus`  to mem_wb
- mem_we  out  1  to mem_wb
- stall_req  out  1  to ctrl; holds the stages upstream of mem
- excp_align  out  1  one-cycle misalignment flag
- bus_err  out  1  one-cycle timeout flag

## Operation
- FSM states: IDLE and WAIT. Timeout counter `cnt` is 8 bits wide.
- Non-memory op (IDLE):
  - Outputs pass through combinationally: mem_wdata=ex_wdata, mem_waddr=ex_waddr, mem_we=ex_we.
  - stall_req=0, dmem_req=0.
- Alignment rules:
  - Halfword op with addr[0]=1 is misaligned.
  - Word op with addr[1:0]≠0 is misaligned.
  - Misaligned op: no request, mem_we=0, excp_align=1 for that cycle, no stall.
- Aligned memory op, in IDLE or WAIT: dmem_req=1 and dmem_addr, dmem_sel, dmem_we, dmem_wdata are held stable.
  - No ack: stall_req=1, mem_we=0 (bubble into mem_wb), state goes to WAIT, cnt increments.
  - Ack: stall_req=0, state goes to IDLE, cnt clears.
    - Load: mem_we=ex_we, mem_waddr=ex_waddr, mem_wdata=extended rdata.
    - Store: mem_we=0.
- Byte-lane select:
  - Byte: sel = 4'b1000 >> addr[1:0].
  - Half: addr[1]=0 gives 4'b1100, addr[1]=1 gives 4'b0011.
  - Word: 4'b1111.
- Store data: byte is replicated ×4, half is replicated ×2.
- Load extension: LB/LH sign-extend the selected lane, LBU/LHU zero-extend.
- Timeout: in WAIT, when cnt reaches TIMEOUT-1 with no ack:
  - Same cycle: bus_err=1, stall_req=0, mem_we=0.
  - Next state IDLE.
  - A late ack arriving in IDLE with req=0 is ignored.
- Reset (rst=1 at an edge, including mid-WAIT): state←IDLE, cnt←0. While rst=1, all outputs are 0 (`ZeroData`, `ZeroDataAddr`, `WriteDisable`, req/stall/flags 0).

## Timing
- Pass-through latency: 0 cycles (combinational path to mem_wb inputs).
- Zero-wait memory (ack in the request cycle): 0 stall cycles.
- N-cycle memory: stall_req high for N cycles; result presented in the ack cycle; mem_wb captures it at the next edge.
- Request outputs are stable for the whole transfer, since upstream inputs are held by the stall.
- bus_err and excp_align are never asserted together; each is high for exactly one cycle.

## Structure
- The following belong in defines.v (shared package):
  - New load/store aluop codes.
  - `DmemSelBus` (3:0).
  - FSM state encodings `MemIdle` / `MemWait`.
- One sub-module is natural: `mem_lane`, combinational. It computes sel, store replication, load extraction/extension and the alignment check from aluop and addr[1:0].
- The FSM and the timeout counter live in `mem`.

## Test plan
- ALU op, ex_wdata=0x12345678, waddr=5, we=1 → same cycle mem_wdata=0x12345678, mem_waddr=5, mem_we=1, stall_req=0, dmem_req=0.
- LB addr=0x103, rdata=0x000000F0, ack after 3 cycles → stall_req high 3 cycles, then mem_wdata=0xFFFFFFF0, sel=4'b0001; LBU under the same conditions → 0x000000F0.
- SH addr=0x102, reg2=0xAAAABEEF, same-cycle ack → sel=4'b0011, dmem_wdata=0xBEEFBEEF, dmem_we=1, mem_we=0, no stall.
- LW addr=0x102 → excp_align=1 one cycle, dmem_req=0, mem_we=0, stall_req=0.
- LW with ack withheld, TIMEOUT=4 → stall_req high 3 cycles, bus_err pulses in the 4th, state returns to IDLE; a late ack has no effect.
- rst=1 in the 2nd WAIT cycle → next cycle state IDLE, dmem_req=0, stall_req=0, all outputs zero; a following ALU op passes through normally.
